// File: rtl/packet_generator.sv
// -----------------------------------------------------------------------------
// packet_generator
//
// Purpose:
//   Builds one five-flit test packet per accepted request. The destination is
//   picked pseudo-randomly from a free-running 32-bit Galois LFSR:
//     - a percentage roll can send the packet to the local node;
//     - otherwise up to 16 candidate nodes are drawn, and the first one that is
//       inside the mesh, reachable from the entry side PORT and not local wins;
//     - if none of the 16 draws is acceptable, the local node is used.
//
// Ports:
//   clk           in   1    single clock, all state on the rising edge
//   reset         in   1    asynchronous active-low reset
//   req           in   1    request one packet (taken only while ready=1)
//   index         in   16   packet sequence number, latched with req
//   ready         out  1    high only while the generator is idle
//   packet_valid  out  1    one-cycle pulse when packet carries a new value
//   packet        out  160  flit0 (header) in [31:0], data flits 1..4 above it
//   packet_count  out  16   (PKTGEN_STATS_EN only) packets produced
//   local_count   out  16   (PKTGEN_STATS_EN only) packets sent to local node
//
// Handshake:
//   A request is taken on a rising edge where req=1 and ready=1. Once taken,
//   ready stays low until the packet has been produced, and req is ignored
//   meanwhile. packet_valid pulses for one cycle; packet then holds its value
//   until the next packet is produced.
//
// Configuration:
//   PKTGEN_STATS_EN - define to add the packet_count/local_count outputs.
// -----------------------------------------------------------------------------
module packet_generator #(
    parameter int          PORT       = 0,
    parameter int          PE_PERCENT = 0,
    parameter int          X_LOCAL    = 2,
    parameter int          Y_LOCAL    = 2,
    parameter int          MESH_X     = 8,
    parameter int          MESH_Y     = 8,
    parameter logic [31:0] SEED       = 32'h1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic [15:0]  index,
    output logic         ready,
    output logic         packet_valid,
    output logic [159:0] packet
`ifdef PKTGEN_STATS_EN
    ,
    output logic [15:0]  packet_count,
    output logic [15:0]  local_count
`endif
);

    localparam logic [31:0] TAPS     = 32'h80200003;
    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [2:0]  X_LOC    = 3'(X_LOCAL);
    localparam logic [2:0]  Y_LOC    = 3'(Y_LOCAL);
    localparam logic [2:0]  PORT_ID  = 3'(PORT);
    localparam logic [6:0]  PE_THR   = 7'(PE_PERCENT);
    localparam logic [3:0]  MX       = 4'(MESH_X);
    localparam logic [3:0]  MY       = 4'(MESH_Y);

    typedef enum logic [1:0] {IDLE, ROLL, DRAW, DONE} state_t;

    state_t       state, state_next;
    logic [31:0]  lfsr;
    logic [15:0]  idx_q, idx_next;
    logic [2:0]   dest_x, dest_x_next;
    logic [2:0]   dest_y, dest_y_next;
    logic [3:0]   draw_cnt, draw_cnt_next;

    logic [6:0]   roll_raw, roll_val;
    logic [2:0]   cand_x, cand_y;
    logic         cand_in_mesh, cand_port_ok, cand_local, cand_ok;
    logic [159:0] pkt_build;

    // Percentage roll: 7-bit value folded into 0..99.
    assign roll_raw = lfsr[6:0];
    assign roll_val = (roll_raw >= 7'd100) ? (roll_raw - 7'd100) : roll_raw;

    assign cand_x       = lfsr[10:8];
    assign cand_y       = lfsr[13:11];
    assign cand_in_mesh = ({1'b0, cand_x} < MX) && ({1'b0, cand_y} < MY);
    assign cand_local   = (cand_x == X_LOC) && (cand_y == Y_LOC);

    // Region reachable from the entry side.
    always_comb begin
        cand_port_ok = 1'b1;
        case (PORT)
            1:       cand_port_ok = (cand_x <= X_LOC);
            2:       cand_port_ok = (cand_x >= X_LOC);
            3:       cand_port_ok = (cand_x == X_LOC) && (cand_y <= Y_LOC);
            4:       cand_port_ok = (cand_x == X_LOC) && (cand_y >= Y_LOC);
            default: cand_port_ok = 1'b1;
        endcase
    end

    assign cand_ok = cand_in_mesh && cand_port_ok && !cand_local;

    // Next-state logic.
    always_comb begin
        state_next    = state;
        idx_next      = idx_q;
        dest_x_next   = dest_x;
        dest_y_next   = dest_y;
        draw_cnt_next = draw_cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    idx_next   = index;
                    state_next = ROLL;
                end
            end
            ROLL: begin
                if (roll_val < PE_THR) begin
                    dest_x_next = X_LOC;
                    dest_y_next = Y_LOC;
                    state_next  = DONE;
                end else begin
                    draw_cnt_next = 4'd0;
                    state_next    = DRAW;
                end
            end
            DRAW: begin
                if (cand_ok) begin
                    dest_x_next = cand_x;
                    dest_y_next = cand_y;
                    state_next  = DONE;
                end else if (draw_cnt == 4'd15) begin
                    // Sixteenth rejection: give up and stay local.
                    dest_x_next = X_LOC;
                    dest_y_next = Y_LOC;
                    state_next  = DONE;
                end else begin
                    draw_cnt_next = draw_cnt + 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Packet image, captured on the edge that leaves DONE.
    always_comb begin
        pkt_build        = '0;
        pkt_build[31:0]  = {2'b10, dest_x, dest_y, idx_q, 5'b00000, PORT_ID};
        for (int k = 1; k <= 4; k++) begin
            pkt_build[32*k +: 32] = {8'(k), idx_q[7:0], lfsr[15:0]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            lfsr         <= SEED_EFF;
            idx_q        <= '0;
            dest_x       <= '0;
            dest_y       <= '0;
            draw_cnt     <= '0;
            packet       <= '0;
            packet_valid <= 1'b0;
        end else begin
            state        <= state_next;
            lfsr         <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
            idx_q        <= idx_next;
            dest_x       <= dest_x_next;
            dest_y       <= dest_y_next;
            draw_cnt     <= draw_cnt_next;
            packet_valid <= (state == DONE);
            if (state == DONE) begin
                packet <= pkt_build;
            end
        end
    end

    assign ready = (state == IDLE);

`ifdef PKTGEN_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            packet_count <= '0;
            local_count  <= '0;
        end else if (state == DONE) begin
            packet_count <= packet_count + 16'd1;
            if ((dest_x == X_LOC) && (dest_y == Y_LOC)) begin
                local_count <= local_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_packet_generator.sv
// -----------------------------------------------------------------------------
// tb_packet_generator
//
// Five generator instances with different entry sides, roll percentages and
// mesh shapes. Each packet is predicted from the LFSR value seen in the roll
// cycle by walking the selection rules directly (roll, up to 16 draws, local
// fallback), giving expected packet, latency and local flag.
// Latency is counted in cycles starting with the cycle req is presented.
// -----------------------------------------------------------------------------
module tb_packet_generator;

    localparam int ND = 5;
    localparam int          C_PORT [ND] = '{0, 1, 3, 4, 2};
    localparam int          C_PE   [ND] = '{30, 100, 0, 0, 50};
    localparam int          C_XL   [ND] = '{2, 2, 2, 2, 1};
    localparam int          C_YL   [ND] = '{2, 2, 2, 7, 1};
    localparam int          C_MX   [ND] = '{8, 8, 8, 8, 4};
    localparam int          C_MY   [ND] = '{8, 8, 8, 8, 3};
    localparam logic [31:0] C_SEED [ND] = '{32'h0000ACE1, 32'h0, 32'h12345678,
                                            32'hDEADBEEF, 32'h0BADF00D};

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic         req_s [ND];
    logic [15:0]  idx_s [ND];
    logic         rdy   [ND];
    logic         vld   [ND];
    logic [159:0] pkt   [ND];
`ifdef PKTGEN_STATS_EN
    logic [15:0]  pcnt  [ND];
    logic [15:0]  lcnt  [ND];
`endif

    for (genvar g = 0; g < ND; g++) begin : g_dut
        packet_generator #(
            .PORT       (C_PORT[g]),
            .PE_PERCENT (C_PE[g]),
            .X_LOCAL    (C_XL[g]),
            .Y_LOCAL    (C_YL[g]),
            .MESH_X     (C_MX[g]),
            .MESH_Y     (C_MY[g]),
            .SEED       (C_SEED[g])
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .req          (req_s[g]),
            .index        (idx_s[g]),
            .ready        (rdy[g]),
            .packet_valid (vld[g]),
            .packet       (pkt[g])
`ifdef PKTGEN_STATS_EN
            ,
            .packet_count (pcnt[g]),
            .local_count  (lcnt[g])
`endif
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        logic [31:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 32'h80200003;
        return n;
    endfunction

    function automatic bit legal(input int d, input int cx, input int cy);
        if (cx >= C_MX[d] || cy >= C_MY[d]) return 1'b0;
        case (C_PORT[d])
            1: return cx <= C_XL[d];
            2: return cx >= C_XL[d];
            3: return (cx == C_XL[d]) && (cy <= C_YL[d]);
            4: return (cx == C_XL[d]) && (cy >= C_YL[d]);
            default: return 1'b1;
        endcase
    endfunction

    function automatic void predict(input int d, input logic [31:0] l_roll,
                                    input logic [15:0] idx,
                                    output logic [159:0] p, output int lat,
                                    output bit loc);
        logic [31:0] l;
        int r, dx, dy, cx, cy;
        bit found;
        l = l_roll;
        r = int'(l[6:0]);
        if (r >= 100) r -= 100;
        dx = C_XL[d];
        dy = C_YL[d];
        lat = 3;
        if (r >= C_PE[d]) begin
            found = 1'b0;
            for (int n = 1; n <= 16 && !found; n++) begin
                l = lfsr_step(l);
                cx = int'(l[10:8]);
                cy = int'(l[13:11]);
                lat = 3 + n;
                if (legal(d, cx, cy) && !(cx == C_XL[d] && cy == C_YL[d])) begin
                    found = 1'b1;
                    dx = cx;
                    dy = cy;
                end
            end
        end
        l = lfsr_step(l);  // value seen in the output cycle
        loc = (dx == C_XL[d]) && (dy == C_YL[d]);
        p = '0;
        p[31:0] = {2'b10, 3'(dx), 3'(dy), idx, 5'b00000, 3'(C_PORT[d])};
        for (int k = 1; k <= 4; k++) p[32*k +: 32] = {8'(k), idx[7:0], l[15:0]};
    endfunction

    // Free-running copy of each LFSR sequence.
    logic [31:0] m_lfsr [ND];
    always @(posedge clk or negedge reset) begin
        for (int d = 0; d < ND; d++) begin
            if (!reset) m_lfsr[d] <= (C_SEED[d] == 32'h0) ? 32'h1 : C_SEED[d];
            else        m_lfsr[d] <= lfsr_step(m_lfsr[d]);
        end
    end

    int exp_pkts [ND];
    int exp_locs [ND];

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic do_req(input int d, input logic [15:0] idx, input bit hold,
                          output logic [159:0] got_pkt, output int got_lat);
        logic [159:0] exp_pkt;
        int exp_lat;
        bit loc;
        int lat;
        bit seen;
        check("ready_idle", 160'(rdy[d]), 160'(1));
        req_s[d] = 1'b1;
        idx_s[d] = idx;
        @(negedge clk);
        if (!hold) req_s[d] = 1'b0;
        idx_s[d] = 16'($urandom_range(0, 65535));
        predict(d, m_lfsr[d], idx, exp_pkt, exp_lat, loc);
        lat = 1;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            if (vld[d]) begin
                seen = 1'b1;
            end else begin
                check("ready_busy", 160'(rdy[d]), 160'(0));
                @(negedge clk);
                lat++;
            end
        end
        req_s[d] = 1'b0;
        check("valid_seen", 160'(seen), 160'(1));
        check("latency", 160'(lat), 160'(exp_lat));
        check("packet", pkt[d], exp_pkt);
        got_pkt = pkt[d];
        got_lat = lat;
        exp_pkts[d]++;
        if (loc) exp_locs[d]++;
        @(negedge clk);
        check("valid_pulse", 160'(vld[d]), 160'(0));
        check("packet_hold", pkt[d], exp_pkt);
        check("ready_back", 160'(rdy[d]), 160'(1));
    endtask

    task automatic run_random(input int d, input int count);
        logic [159:0] p;
        int l;
        for (int i = 0; i < count; i++) begin
            do_req(d, 16'($urandom_range(0, 65535)), bit'($urandom_range(0, 1)), p, l);
        end
    endtask

    // ---------------- main ----------------
    initial begin
        logic [159:0] p;
        int l;
        reset = 1'b0;
        for (int d = 0; d < ND; d++) begin
            req_s[d] = 1'b0;
            idx_s[d] = '0;
            exp_pkts[d] = 0;
            exp_locs[d] = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check("rst_ready", 160'(rdy[d]), 160'(1));
            check("rst_valid", 160'(vld[d]), 160'(0));
            check("rst_packet", pkt[d], 160'h0);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Always-local roll, X_POS entry, index 5.
        do_req(1, 16'h0005, 1'b0, p, l);
        check("pe100_lat", 160'(l), 160'(3));
        check("pe100_hdr_top", 160'(p[31:24]), 160'(8'b10_010_010));
        check("pe100_hdr_idx", 160'(p[23:8]), 160'(16'h0005));
        check("pe100_hdr_port", 160'(p[2:0]), 160'(3'd1));
        run_random(1, 20);

        run_random(0, 200);

        // Y_POS entry: destination stays in column 2 at or below row 2.
        for (int i = 0; i < 1000; i++) begin
            do_req(2, 16'($urandom_range(0, 65535)), bit'($urandom_range(0, 1)), p, l);
            check("ypos_region", 160'((p[29:27] == 3'd2) && (p[26:24] <= 3'd2)), 160'(1));
        end

        // Y_NEG entry from the top row: nothing legal, always the full fallback.
        for (int i = 0; i < 30; i++) begin
            do_req(3, 16'($urandom_range(0, 65535)), bit'($urandom_range(0, 1)), p, l);
            check("yneg_lat", 160'(l), 160'(19));
            check("yneg_dest", 160'(p[29:24]), 160'(6'b010_111));
        end

        run_random(4, 200);

        // Reset in the middle of a request on instance 0.
        req_s[0] = 1'b1;
        idx_s[0] = 16'h1234;
        @(negedge clk);
        req_s[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            check("abort_ready", 160'(rdy[d]), 160'(1));
            check("abort_valid", 160'(vld[d]), 160'(0));
            check("abort_packet", pkt[d], 160'h0);
            exp_pkts[d] = 0;
            exp_locs[d] = 0;
        end
        repeat (3) begin
            @(negedge clk);
            check("abort_hold_valid", 160'(vld[0]), 160'(0));
        end
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("abort_after_valid", 160'(vld[0]), 160'(0));
            check("abort_after_ready", 160'(rdy[0]), 160'(1));
        end

        run_random(0, 20);
        run_random(1, 10);

`ifdef PKTGEN_STATS_EN
        for (int d = 0; d < ND; d++) begin
            check("stat_packets", 160'(pcnt[d]), 160'(16'(exp_pkts[d])));
            check("stat_local", 160'(lcnt[d]), 160'(16'(exp_locs[d])));
        end
        check("stat_pe100_packets", 160'(pcnt[1]), 160'(16'd10));
        check("stat_pe100_local", 160'(lcnt[1]), 160'(16'd10));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/packet_generator.md
PACKET_GENERATOR -- requirements
Module: packet_generator

Interface
REQ-001 SHALL have parameter PORT, default 0, giving the entry side: 0=PE, 1=X_POS, 2=X_NEG, 3=Y_POS, 4=Y_NEG.
REQ-002 SHALL have parameter PE_PERCENT, default 0, giving the percentage (0..100) of packets addressed to the local node.
REQ-003 SHALL have parameters X_LOCAL and Y_LOCAL, default 2 each, giving the local node coordinates.
REQ-004 SHALL have parameters MESH_X and MESH_Y, default 8 each, range 1..8, giving the mesh dimensions.
REQ-005 SHALL have parameter SEED, default 32'h1, giving the LFSR reset value; a value of 0 SHALL be replaced by 1.
REQ-006 Ports: clk  in  1  single clock, all state on rising edge.
REQ-007 Ports: reset  in  1  asynchronous active-low reset.
REQ-008 Ports: req  in  1  request one packet.
REQ-009 Ports: index  in  16  packet sequence number.
REQ-010 Ports: ready  out  1  high only in IDLE.
REQ-011 Ports: packet_valid  out  1  one-cycle pulse when packet is valid.
REQ-012 Ports: packet  out  160  five 32-bit flits; flit0 (header) in [31:0], data flits 1..4 in ascending 32-bit slices.

Function
REQ-013 LFSR: 32-bit Galois LFSR, taps 32'h80200003, SHALL advance every cycle out of reset.
REQ-014 FSM states SHALL be IDLE, ROLL, DRAW, DONE.
REQ-015 IDLE: req=1 latches index and moves to ROLL; req in any other state SHALL be ignored.
REQ-016 ROLL: r=lfsr[6:0], minus 100 if r>=100; r<PE_PERCENT sets the destination to (X_LOCAL,Y_LOCAL) and goes to DONE; otherwise clears the draw counter and goes to DRAW.
REQ-017 DRAW, per cycle: candidate x=lfsr[10:8], y=lfsr[13:11]; accept and go to DONE if legal and not local.
REQ-018 DRAW: after 16 rejected draws, SHALL use the local node as destination and go to DONE.
REQ-019 Legal region: x<MESH_X and y<MESH_Y, plus per PORT:
- PE: anywhere
- X_POS: x<=X_LOCAL
- X_NEG: x>=X_LOCAL
- Y_POS: x==X_LOCAL, y<=Y_LOCAL
- Y_NEG: x==X_LOCAL, y>=Y_LOCAL
REQ-020 DONE: packet registered and packet_valid=1 for exactly one cycle, then IDLE.
REQ-021 Header flit: [31:30]=2'b10, [29:27]=dest x, [26:24]=dest y, [23:8]=index, [7:3]=0, [2:0]=PORT.
REQ-022 Data flit k (k=1..4): [31:24]=k, [23:16]=index[7:0], [15:0]=lfsr[15:0] sampled in DONE.
REQ-023 Latency, req edge to valid: 3 cycles for local-by-roll; 3+n for n draw cycles; maximum 19.
REQ-024 packet SHALL hold its value until the next DONE.

Reset
REQ-025 reset low: state IDLE, ready=1, packet_valid=0, packet=0, lfsr=SEED, counters 0.
REQ-026 Reset asserted mid-request SHALL abort it with no valid pulse.

Configuration
REQ-027 Macro PKTGEN_STATS_EN defined: adds outputs packet_count (16) and local_count (16), incremented in DONE (local_count only when dest==local), wrapping at 16'hFFFF.
REQ-028 PKTGEN_STATS_EN undefined: those ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Scenario: hold reset low -> ready=1, packet_valid=0, packet=160'h0.
REQ-030 Scenario: PE_PERCENT=100, PORT=1, local (2,2), req with index=5 -> valid 3 cycles later; header [31:24]=8'b10_010_010, [23:8]=16'h0005, [2:0]=3'd1.
REQ-031 Scenario: PE_PERCENT=0, PORT=3, local (2,2), 1000 requests -> every dest x==2, y in {0,1}, never (2,2).
REQ-032 Scenario: PE_PERCENT=0, PORT=4, Y_LOCAL=7, MESH_Y=8 -> no legal non-local node, so dest=(2,7) and latency=19 every time.
REQ-033 Scenario: req held high during DRAW -> ready=0, exactly one packet per IDLE acceptance.
REQ-034 Scenario: PKTGEN_STATS_EN defined, PE_PERCENT=100, 10 requests -> packet_count=10, local_count=10.
